fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, width of rm0 and instruction words.
REQ-002 SHALL have parameter DEPTH, default 4, number of entries; power of two, >= 2.
REQ-003 SHALL have clk  input  1  single clock; all state updates on falling edge of clk.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have flush  input  1  discard all entries (branch redirect).
REQ-006 SHALL have in_valid  input  1  fetch presents an entry.
REQ-007 SHALL have in_ready  output  1  queue can accept an entry.
REQ-008 SHALL have rm0_in  input  WORD_SIZE  PC of the fetched instruction.
REQ-009 SHALL have instruction_in  input  WORD_SIZE  fetched instruction.
REQ-010 SHALL have out_valid  output  1  head entry valid for decode.
REQ-011 SHALL have out_ready  input  1  decode consumes the head entry.
REQ-012 SHALL have rm0_out  output  WORD_SIZE  head entry PC.
REQ-013 SHALL have instruction_out  output  WORD_SIZE  head entry instruction.
REQ-014 SHALL have count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 SHALL push on a falling edge when in_valid && in_ready && !flush; pop when out_valid && out_ready && !flush.
REQ-016 SHALL drive in_ready = (count < DEPTH), combinational from state only; no push into a full queue, even with simultaneous pop.
REQ-017 SHALL drive out_valid = (count != 0); rm0_out/instruction_out = head entry, all-zero when empty.
REQ-018 SHALL keep count unchanged on simultaneous push and pop; +1 on push only; -1 on pop only.
REQ-019 SHALL advance write/read pointers modulo DEPTH (wrap DEPTH-1 -> 0).
REQ-020 SHALL on flush: set count and both pointers to 0 at the next falling edge; same-cycle push and pop are dropped; flush has priority over push/pop.
REQ-021 SHALL have minimum latency of one falling edge from push to out_valid when compiled without bypass.
REQ-022 SHALL preserve FIFO order; entries never duplicated or reordered.
REQ-023 SHALL hold head outputs stable while out_valid && !out_ready && !flush.

Reset
REQ-024 SHALL on rst at a falling edge: count=0, pointers=0, out_valid=0, in_ready=1, rm0_out=0, instruction_out=0.
REQ-025 SHALL give rst priority over flush, push and pop; reset mid-operation drops all entries.
REQ-026 SHALL not require storage array reset; outputs are masked to zero while empty.

Configuration
REQ-027 SHALL compile bypass path only when macro FETCH_QUEUE_BYPASS_EN is defined.
REQ-028 With FETCH_QUEUE_BYPASS_EN: when count==0, in_valid=1, flush=0, out_valid=1 and outputs equal inputs combinationally; if out_ready also 1, entry is consumed and not stored (count stays 0).
REQ-029 Without FETCH_QUEUE_BYPASS_EN: out_valid depends on count only; empty queue never asserts out_valid.

Structure
REQ-030 SHALL place the entry layout (rm0, instruction) and default DEPTH constant in shared package fetch_pkg.
REQ-031 SHALL instantiate one sub-module fetch_queue_ram: DEPTH x 2*WORD_SIZE storage, one write port, one asynchronous read port.
REQ-032 SHALL keep pointer/count control in fetch_queue itself.

Verification
REQ-033 Reset: assert rst one edge -> count=0, out_valid=0, in_ready=1, outputs 0.
REQ-034 Fill: DEPTH=4, push PCs 0x0,0x4,0x8,0xC with out_ready=0 -> count=4, in_ready=0; fifth push 0x10 ignored; drain yields 0x0..0xC in order.
REQ-035 Wrap: push/pop 10 entries with out_ready=1 continuously -> pointers wrap, every PC emitted once in order, count oscillates between 0 and 1.
REQ-036 Flush: count=3, flush=1 with in_valid=1 (PC 0x40) -> next edge count=0, out_valid=0, 0x40 not stored.
REQ-037 Full simultaneous: count=4, in_valid=1, out_ready=1 -> pop only, count=3, new entry dropped.
REQ-038 Bypass (FETCH_QUEUE_BYPASS_EN): empty, push PC 0x80 with out_ready=1 -> rm0_out=0x80 same cycle, count remains 0; without macro -> out_valid=1 one edge later.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared definitions for the fetch queue.
//
// Entry layout: an entry is stored as one packed word {rm0, instruction},
// rm0 (the PC) in the upper half and the instruction in the lower half.
// fetch_entry_t spells out that layout for the default word size; the
// parameterised RTL packs and unpacks with the same field order.
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (see fetch_queue.sv).
package fetch_pkg;

  localparam int DEFAULT_WORD_SIZE = 32;
  localparam int DEFAULT_DEPTH     = 4;
  localparam int ENTRY_FIELDS      = 2;

  typedef struct packed {
    logic [DEFAULT_WORD_SIZE-1:0] rm0;
    logic [DEFAULT_WORD_SIZE-1:0] instruction;
  } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_queue_ram.sv
// fetch_queue_ram -- DEPTH x (ENTRY_FIELDS*WORD_SIZE) storage for the fetch queue.
//
// Ports:
//   clk    in   write clock, written on the falling edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   packed entry {rm0, instruction}
//   raddr  in   read address
//   rdata  out  packed entry at raddr, asynchronous read
//
// The array has no reset; the queue masks its outputs while empty.
module fetch_queue_ram
  import fetch_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int DEPTH     = DEFAULT_DEPTH
) (
  input  logic                              clk,
  input  logic                              we,
  input  logic [$clog2(DEPTH)-1:0]          waddr,
  input  logic [ENTRY_FIELDS*WORD_SIZE-1:0] wdata,
  input  logic [$clog2(DEPTH)-1:0]          raddr,
  output logic [ENTRY_FIELDS*WORD_SIZE-1:0] rdata
);

  logic [ENTRY_FIELDS*WORD_SIZE-1:0] mem_q [DEPTH];

  always_ff @(negedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : fetch_queue_ram

// File: rtl/fetch_queue.sv
// fetch_queue -- instruction fetch queue between fetch and decode.
//
// All state updates on the falling edge of clk. rst is synchronous,
// active-high and beats flush; flush beats push and pop.
//
// Ports:
//   clk              in   clock (falling-edge active)
//   rst              in   synchronous active-high reset
//   flush            in   discard all entries (branch redirect)
//   in_valid         in   fetch presents an entry
//   in_ready         out  queue can accept an entry (count < DEPTH)
//   rm0_in           in   PC of the fetched instruction
//   instruction_in   in   fetched instruction
//   out_valid        out  head entry valid for decode
//   out_ready        in   decode consumes the head entry
//   rm0_out          out  head PC, zero when empty
//   instruction_out  out  head instruction, zero when empty
//   count            out  current occupancy
//
// Macro FETCH_QUEUE_BYPASS_EN: when defined, an entry arriving at an empty
// queue is presented on the outputs in the same cycle; if decode takes it
// right away it is never written into storage.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int DEPTH     = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_SIZE-1:0]     rm0_in,
  input  logic [WORD_SIZE-1:0]     instruction_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_SIZE-1:0]     rm0_out,
  output logic [WORD_SIZE-1:0]     instruction_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ENTRY_FIELDS * WORD_SIZE;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          empty;
  logic          push_st;
  logic          pop_st;
  logic          bypass_take;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;
  logic [WORD_SIZE-1:0] head_rm0;
  logic [WORD_SIZE-1:0] head_instr;

  fetch_queue_ram #(
    .WORD_SIZE (WORD_SIZE),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_st),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  assign wr_entry = {rm0_in, instruction_in};
  assign empty    = (count_q == '0);
  assign in_ready = (count_q < DEPTH_C);
  assign count    = count_q;

  // Stored head, forced to zero while nothing is stored.
  assign head_rm0   = empty ? '0 : rd_entry[EW-1:WORD_SIZE];
  assign head_instr = empty ? '0 : rd_entry[WORD_SIZE-1:0];

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass_act;
  assign bypass_act      = empty && in_valid && !flush;
  assign bypass_take     = bypass_act && out_ready;
  assign out_valid       = !empty || bypass_act;
  assign rm0_out         = bypass_act ? rm0_in : head_rm0;
  assign instruction_out = bypass_act ? instruction_in : head_instr;
`else
  assign bypass_take     = 1'b0;
  assign out_valid       = !empty;
  assign rm0_out         = head_rm0;
  assign instruction_out = head_instr;
`endif

  // A bypassed entry consumed by decode in the same cycle is never stored.
  assign push_st = in_valid && in_ready && !flush && !bypass_take;
  assign pop_st  = !empty && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointer increment wraps by itself.
      if (push_st) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_st)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_st, pop_st})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue -- directed self-checking bench for fetch_queue (DEPTH=4,
// WORD_SIZE=32). Inputs change and outputs are checked 1 time unit after
// the falling (active) edge. Expectations follow FETCH_QUEUE_BYPASS_EN.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rm0_in;
  logic [31:0] instruction_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rm0_out;
  logic [31:0] instruction_out;
  logic [2:0]  count;

  int n_chk;
  int n_bad;

  fetch_queue #(.WORD_SIZE(32), .DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .rm0_in          (rm0_in),
    .instruction_in  (instruction_in),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .rm0_out         (rm0_out),
    .instruction_out (instruction_out),
    .count           (count)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return 32'hA500_0000 ^ pc;
  endfunction

  task automatic drive_push(input logic [31:0] pc);
    in_valid       = 1'b1;
    rm0_in         = pc;
    instruction_in = ins_of(pc);
  endtask

  task automatic idle_in();
    in_valid       = 1'b0;
    rm0_in         = '0;
    instruction_in = '0;
  endtask

  // Push a list of PCs with out_ready low.
  task automatic fill(input logic [31:0] base, input int n);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive_push(base + 32'(4 * i));
      tick();
    end
    idle_in();
  endtask

  // Pop n entries, checking the head before each pop.
  task automatic drain(input string tag, input logic [31:0] base, input int n);
    idle_in();
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_pc"}, 64'(rm0_out), 64'(base + 32'(4 * i)));
      chk({tag, "_ins"}, 64'(instruction_out), 64'(ins_of(base + 32'(4 * i))));
      tick();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    idle_in();

    // Reset
    tick();
    rst = 1'b0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ovalid", 64'(out_valid), 64'd0);
    chk("rst_iready", 64'(in_ready), 64'd1);
    chk("rst_pc", 64'(rm0_out), 64'd0);
    chk("rst_ins", 64'(instruction_out), 64'd0);

    // Fill to DEPTH, fifth push ignored, head held, drain in order
    fill(32'h0, 1);
    chk("fill1_count", 64'(count), 64'd1);
    chk("fill1_ovalid", 64'(out_valid), 64'd1);
    fill(32'h4, 3);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_iready", 64'(in_ready), 64'd0);
    drive_push(32'h10);
    tick();
    idle_in();
    chk("fifth_count", 64'(count), 64'd4);
    chk("hold_pc", 64'(rm0_out), 64'h0);
    drain("fill_drain", 32'h0, 4);
    chk("drained_count", 64'(count), 64'd0);
    chk("drained_ovalid", 64'(out_valid), 64'd0);
    chk("drained_pc", 64'(rm0_out), 64'd0);

    // Full with simultaneous push and pop: pop only
    fill(32'h100, 4);
    drive_push(32'h200);
    out_ready = 1'b1;
    tick();
    idle_in();
    out_ready = 1'b0;
    chk("fullsim_count", 64'(count), 64'd3);
    drain("fullsim_drain", 32'h104, 3);
    chk("fullsim_empty", 64'(count), 64'd0);

    // Wrap: 10 entries streamed with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) drive_push(32'h300 + 32'(4 * i));
      else idle_in();
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      chk("wrap_ovalid", 64'(out_valid), 64'(i < 10));
      chk("wrap_pc", 64'(rm0_out), (i < 10) ? 64'(32'h300 + 32'(4 * i)) : 64'd0);
      tick();
      chk("wrap_count", 64'(count), 64'd0);
`else
      chk("wrap_ovalid", 64'(out_valid), 64'(i > 0));
      chk("wrap_pc", 64'(rm0_out), (i > 0) ? 64'(32'h300 + 32'(4 * (i - 1))) : 64'd0);
      tick();
      chk("wrap_count", 64'(count), (i < 10) ? 64'd1 : 64'd0);
`endif
    end
    out_ready = 1'b0;

    // Flush with count=3 and read pointer away from 0
    fill(32'h400, 4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("preflush_count", 64'(count), 64'd3);
    flush = 1'b1;
    out_ready = 1'b1;
    drive_push(32'h40);
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    idle_in();
    #1;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_ovalid", 64'(out_valid), 64'd0);
    chk("flush_pc", 64'(rm0_out), 64'd0);
    fill(32'h500, 1);
    chk("postflush_count", 64'(count), 64'd1);
    chk("postflush_pc", 64'(rm0_out), 64'h500);
    drain("postflush_drain", 32'h500, 1);

    // Reset mid-operation beats flush, push and pop
    fill(32'h600, 2);
    rst = 1'b1;
    flush = 1'b1;
    out_ready = 1'b1;
    drive_push(32'h700);
    tick();
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    idle_in();
    #1;
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_ovalid", 64'(out_valid), 64'd0);
    chk("midrst_iready", 64'(in_ready), 64'd1);
    chk("midrst_pc", 64'(rm0_out), 64'd0);

    // Empty queue, push 0x80 with out_ready high
    out_ready = 1'b1;
    drive_push(32'h80);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_ovalid", 64'(out_valid), 64'd1);
    chk("byp_pc", 64'(rm0_out), 64'h80);
    chk("byp_ins", 64'(instruction_out), 64'(ins_of(32'h80)));
    tick();
    idle_in();
    #1;
    chk("byp_count", 64'(count), 64'd0);
    chk("byp_after", 64'(out_valid), 64'd0);
`else
    chk("nobyp_ovalid0", 64'(out_valid), 64'd0);
    chk("nobyp_pc0", 64'(rm0_out), 64'd0);
    tick();
    idle_in();
    #1;
    chk("nobyp_count", 64'(count), 64'd1);
    chk("nobyp_ovalid1", 64'(out_valid), 64'd1);
    chk("nobyp_pc1", 64'(rm0_out), 64'h80);
    tick();
    chk("nobyp_popped", 64'(count), 64'd0);
`endif
    out_ready = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule : tb_fetch_queue
